// File: rtl/i2c_bus_monitor.sv
// ----------------------------------------------------------------------------
// i2c_bus_monitor
//
// Purpose:
//   Protocol-level I2C bus observer. It sits downstream of the SCL/SDA edge
//   detectors and turns synchronized line levels plus one-cycle edge pulses
//   into bus events: START, repeated START, STOP, received bytes (MSB first),
//   the ACK/NACK bit after each byte, a bus-busy level, and an SCL-stuck-low
//   timeout.
//
// Parameters:
//   TO_W         width of the SCL-low timeout counter
//   TIMEOUT_CYC  clk cycles of SCL held low while busy before timeout;
//                0 disables the timeout entirely
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   scl_d/sda_d  synchronized SCL/SDA levels
//   scl_pos/neg  one-cycle SCL rising/falling edge pulses
//   sda_pos/neg  one-cycle SDA rising/falling edge pulses
//   start_det    pulse: START seen while idle
//   rstart_det   pulse: repeated START seen while busy
//   stop_det     pulse: STOP seen (also reported while idle)
//   bus_busy     level: high between START and STOP/timeout
//   rx_byte      last completed byte, held until the next one
//   byte_valid   pulse: rx_byte updated
//   is_addr      qualifies byte_valid: byte was the first after a (r)START
//   ack_bit      sampled 9th bit (0 = ACK), held until the next one
//   ack_valid    pulse: ack_bit updated
//   timeout      pulse: SCL stuck low while busy
//
// All outputs are registered; pulses appear the cycle after the input pulse
// that qualifies them.
// ----------------------------------------------------------------------------
module i2c_bus_monitor #(
    parameter int TO_W        = 16,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_d,
    input  logic       sda_d,
    input  logic       scl_pos,
    input  logic       scl_neg,
    input  logic       sda_pos,
    input  logic       sda_neg,
    output logic       start_det,
    output logic       rstart_det,
    output logic       stop_det,
    output logic       bus_busy,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       is_addr,
    output logic       ack_bit,
    output logic       ack_valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BITS = 2'd1,
        ACK  = 2'd2
    } state_t;

    // Counter value on the cycle that completes TIMEOUT_CYC low cycles.
    localparam logic [TO_W-1:0] TO_LAST =
        (TIMEOUT_CYC > 0) ? TO_W'(TIMEOUT_CYC - 1) : '0;

    state_t          state;
    logic [6:0]      sr;        // first seven bits of the byte in flight
    logic [2:0]      bit_cnt;
    logic            first;     // next completed byte is the address byte
    logic [TO_W-1:0] to_cnt;

    logic start_cond;
    logic stop_cond;
    logic to_hit;

    // An SDA edge that coincides with an SCL rising edge is a data bit, not
    // a bus condition.
    assign start_cond = sda_neg & scl_d & ~scl_pos;
    assign stop_cond  = sda_pos & scl_d & ~scl_pos;

    assign to_hit = (TIMEOUT_CYC != 0) && bus_busy && !scl_d && (to_cnt == TO_LAST);

    // SCL falling edges carry no information the bit sampling needs.
    logic unused_ok;
    assign unused_ok = scl_neg;

    // NOTE: every register here is state, so it is updated with non-blocking
    // assignments only; the order of the statements below then expresses
    // priority (later assignments in the same cycle win).
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sr         <= '0;
            bit_cnt    <= '0;
            first      <= 1'b0;
            to_cnt     <= '0;
            start_det  <= 1'b0;
            rstart_det <= 1'b0;
            stop_det   <= 1'b0;
            bus_busy   <= 1'b0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            is_addr    <= 1'b0;
            ack_bit    <= 1'b0;
            ack_valid  <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            // Pulse outputs drop back low unless a branch below raises them.
            start_det  <= 1'b0;
            rstart_det <= 1'b0;
            stop_det   <= 1'b0;
            byte_valid <= 1'b0;
            ack_valid  <= 1'b0;
            timeout    <= 1'b0;

            // Consecutive SCL-low cycles while the bus is owned; saturates.
            if (TIMEOUT_CYC == 0 || !bus_busy || scl_d) begin
                to_cnt <= '0;
            end else if (to_cnt != '1) begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (to_hit) begin
                timeout  <= 1'b1;
                bus_busy <= 1'b0;
                state    <= IDLE;
                bit_cnt  <= '0;
                sr       <= '0;
                to_cnt   <= '0;
            end else if (stop_cond) begin
                // Reported even from IDLE: it marks an observed bus release.
                stop_det <= 1'b1;
                bus_busy <= 1'b0;
                state    <= IDLE;
                bit_cnt  <= '0;
                sr       <= '0;
            end else if (start_cond) begin
                if (state == IDLE) begin
                    start_det <= 1'b1;
                end else begin
                    rstart_det <= 1'b1;
                end
                bus_busy <= 1'b1;
                state    <= BITS;
                bit_cnt  <= '0;
                sr       <= '0;
                first    <= 1'b1;
            end else if (scl_pos) begin
                case (state)
                    BITS: begin
                        sr      <= {sr[5:0], sda_d};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            rx_byte    <= {sr, sda_d};
                            byte_valid <= 1'b1;
                            is_addr    <= first;
                            first      <= 1'b0;
                            state      <= ACK;
                        end
                    end
                    ACK: begin
                        ack_bit   <= sda_d;
                        ack_valid <= 1'b1;
                        bit_cnt   <= '0;
                        state     <= BITS;
                    end
                    default: ;  // IDLE: data edges carry no meaning
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// ----------------------------------------------------------------------------
// tb_i2c_bus_monitor
//
// Drives SCL/SDA levels cycle by cycle, derives the edge pulses the upstream
// edge detector would produce, and compares two monitor instances (timeout
// of 20 cycles and timeout disabled) against a transaction-level reference
// model every cycle. Directed sequences check the headline bus scenarios
// against fixed expected values; a randomized phase follows.
// ----------------------------------------------------------------------------
module tb_i2c_bus_monitor;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic scl_d = 1'b1, sda_d = 1'b1;
    logic scl_pos = 1'b0, scl_neg = 1'b0, sda_pos = 1'b0, sda_neg = 1'b0;
    logic prev_scl = 1'b1, prev_sda = 1'b1;

    logic       a_start, a_rstart, a_stop, a_busy, a_bv, a_isad, a_ack, a_av, a_to;
    logic [7:0] a_rx;
    logic       b_start, b_rstart, b_stop, b_busy, b_bv, b_isad, b_ack, b_av, b_to;
    logic [7:0] b_rx;

    int n_checks = 0;
    int n_fail   = 0;

    // Event counters and captured values of the timeout-enabled instance.
    int n_start = 0, n_rstart = 0, n_stop = 0, n_bv = 0, n_av = 0, n_to = 0;
    int n_to_dis = 0;
    logic [7:0] cap_rx = '0;
    logic       cap_isad = 1'b0, cap_ack = 1'b0;

    always #5 clk = ~clk;

    i2c_bus_monitor #(.TO_W(16), .TIMEOUT_CYC(20)) dut (
        .clk(clk), .rst(rst), .scl_d(scl_d), .sda_d(sda_d),
        .scl_pos(scl_pos), .scl_neg(scl_neg), .sda_pos(sda_pos), .sda_neg(sda_neg),
        .start_det(a_start), .rstart_det(a_rstart), .stop_det(a_stop),
        .bus_busy(a_busy), .rx_byte(a_rx), .byte_valid(a_bv), .is_addr(a_isad),
        .ack_bit(a_ack), .ack_valid(a_av), .timeout(a_to)
    );

    i2c_bus_monitor #(.TO_W(16), .TIMEOUT_CYC(0)) dut_no_to (
        .clk(clk), .rst(rst), .scl_d(scl_d), .sda_d(sda_d),
        .scl_pos(scl_pos), .scl_neg(scl_neg), .sda_pos(sda_pos), .sda_neg(sda_neg),
        .start_det(b_start), .rstart_det(b_rstart), .stop_det(b_stop),
        .bus_busy(b_busy), .rx_byte(b_rx), .byte_valid(b_bv), .is_addr(b_isad),
        .ack_bit(b_ack), .ack_valid(b_av), .timeout(b_to)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit busy;
        bit want_ack;   // next sampled bit is the ACK slot
        bit first;
        int nbits;      // data bits collected in the current byte
        int acc;        // value of collected bits
        int low;        // consecutive SCL-low cycles while busy
        bit start, rstart, stop;
        int rx;
        bit bv, isad, ack, av, to;
    } model_t;

    model_t m_a, m_b;

    function automatic model_t model_reset();
        model_t r;
        r = '{default: 0};
        return r;
    endfunction

    function automatic model_t model_step(model_t m, bit r, bit scl, bit sda,
                                          bit sp, bit dp, bit dn, int limit);
        model_t n;
        bit is_start, is_stop;
        if (r) return model_reset();
        n = m;
        n.start = 0; n.rstart = 0; n.stop = 0; n.bv = 0; n.av = 0; n.to = 0;
        is_start = dn && scl && !sp;
        is_stop  = dp && scl && !sp;

        if (!m.busy || scl || limit == 0) begin
            n.low = 0;
        end else if (m.low + 1 >= limit) begin
            n.to = 1; n.busy = 0; n.low = 0; n.nbits = 0; n.acc = 0; n.want_ack = 0;
            return n;
        end else begin
            n.low = m.low + 1;
        end

        if (is_stop) begin
            n.stop = 1; n.busy = 0; n.nbits = 0; n.acc = 0; n.want_ack = 0;
        end else if (is_start) begin
            if (m.busy) n.rstart = 1; else n.start = 1;
            n.busy = 1; n.first = 1; n.nbits = 0; n.acc = 0; n.want_ack = 0;
        end else if (m.busy && sp) begin
            if (m.want_ack) begin
                n.ack = sda; n.av = 1; n.want_ack = 0;
            end else begin
                n.acc   = (m.acc * 2 + int'(sda)) % 256;
                n.nbits = m.nbits + 1;
                if (n.nbits == 8) begin
                    n.rx = n.acc; n.bv = 1; n.isad = m.first; n.first = 0;
                    n.want_ack = 1; n.nbits = 0; n.acc = 0;
                end
            end
        end
        return n;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outs(input string who, input logic [16:0] obs, input model_t m);
        logic [16:0] exp;
        exp = {m.start, m.rstart, m.stop, m.busy, 8'(m.rx), m.bv, m.isad, m.ack, m.av, m.to};
        check({who, ".start_det"},  32'(obs[16]),   32'(exp[16]));
        check({who, ".rstart_det"}, 32'(obs[15]),   32'(exp[15]));
        check({who, ".stop_det"},   32'(obs[14]),   32'(exp[14]));
        check({who, ".bus_busy"},   32'(obs[13]),   32'(exp[13]));
        check({who, ".rx_byte"},    32'(obs[12:5]), 32'(exp[12:5]));
        check({who, ".byte_valid"}, 32'(obs[4]),    32'(exp[4]));
        check({who, ".is_addr"},    32'(obs[3]),    32'(exp[3]));
        check({who, ".ack_bit"},    32'(obs[2]),    32'(exp[2]));
        check({who, ".ack_valid"},  32'(obs[1]),    32'(exp[1]));
        check({who, ".timeout"},    32'(obs[0]),    32'(exp[0]));
    endtask

    // ---------------- stimulus ----------------
    // One clock cycle with the given line levels; edge pulses derived from
    // the previous cycle's levels.
    task automatic cyc(input logic s_scl, input logic s_sda);
        scl_d   = s_scl;
        sda_d   = s_sda;
        scl_pos = s_scl & ~prev_scl;
        scl_neg = ~s_scl & prev_scl;
        sda_pos = s_sda & ~prev_sda;
        sda_neg = ~s_sda & prev_sda;
        @(posedge clk);
        prev_scl = s_scl;
        prev_sda = s_sda;
        m_a = model_step(m_a, rst, s_scl, s_sda, scl_pos, sda_pos, sda_neg, 20);
        m_b = model_step(m_b, rst, s_scl, s_sda, scl_pos, sda_pos, sda_neg, 0);
        #1;
        check_outs("to20", {a_start, a_rstart, a_stop, a_busy, a_rx, a_bv, a_isad, a_ack, a_av, a_to}, m_a);
        check_outs("to0",  {b_start, b_rstart, b_stop, b_busy, b_rx, b_bv, b_isad, b_ack, b_av, b_to}, m_b);
        if (a_start)  n_start++;
        if (a_rstart) n_rstart++;
        if (a_stop)   n_stop++;
        if (a_to)     n_to++;
        if (b_to)     n_to_dis++;
        if (a_bv) begin n_bv++; cap_rx = a_rx; cap_isad = a_isad; end
        if (a_av) begin n_av++; cap_ack = a_ack; end
    endtask

    task automatic reset_cycle();
        rst = 1'b1;
        cyc(prev_scl, prev_sda);
        rst = 1'b0;
    endtask

    task automatic i2c_start();
        cyc(1'b1, 1'b1); cyc(1'b1, 1'b0); cyc(1'b0, 1'b0);
    endtask

    task automatic i2c_rstart();
        cyc(1'b0, 1'b1); cyc(1'b1, 1'b1); cyc(1'b1, 1'b0); cyc(1'b0, 1'b0);
    endtask

    task automatic i2c_stop();
        cyc(1'b0, 1'b0); cyc(1'b1, 1'b0); cyc(1'b1, 1'b1); cyc(1'b1, 1'b1);
    endtask

    task automatic send_bit(input logic b);
        cyc(1'b0, b); cyc(1'b1, b); cyc(1'b1, b); cyc(1'b0, b);
    endtask

    task automatic send_byte(input logic [7:0] v, input logic ackb);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
        send_bit(ackb);
    endtask

    int base_a, base_b;

    initial begin
        m_a = model_reset();
        m_b = model_reset();

        // Reset state
        rst = 1'b1;
        cyc(1'b1, 1'b1); cyc(1'b1, 1'b1);
        rst = 1'b0;
        cyc(1'b1, 1'b1);
        check("reset.bus_busy", 32'(a_busy), 0);
        check("reset.rx_byte", 32'(a_rx), 0);

        // START from idle
        base_a = n_start;
        i2c_start();
        check("start.count", n_start - base_a, 1);
        check("start.bus_busy", 32'(a_busy), 1);

        // Address byte A5 with ACK, then data byte 3C with NACK
        base_a = n_av;
        send_byte(8'hA5, 1'b0);
        check("addr.rx_byte", 32'(cap_rx), 32'hA5);
        check("addr.is_addr", 32'(cap_isad), 1);
        check("addr.ack_bit", 32'(cap_ack), 0);
        check("addr.ack_count", n_av - base_a, 1);
        send_byte(8'h3C, 1'b1);
        check("data.rx_byte", 32'(cap_rx), 32'h3C);
        check("data.is_addr", 32'(cap_isad), 0);
        check("data.ack_bit", 32'(cap_ack), 1);
        i2c_stop();
        check("stop1.bus_busy", 32'(a_busy), 0);

        // START, 4 bits, repeated START, byte FF
        i2c_start();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        base_a = n_bv; base_b = n_rstart;
        i2c_rstart();
        check("rstart.count", n_rstart - base_b, 1);
        check("rstart.partial_bytes", n_bv - base_a, 0);
        send_byte(8'hFF, 1'b0);
        check("rstart.rx_byte", 32'(cap_rx), 32'hFF);
        check("rstart.is_addr", 32'(cap_isad), 1);

        // STOP after 3 bits, then clocking in idle
        i2c_stop();
        i2c_start();
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        base_a = n_bv; base_b = n_stop;
        i2c_stop();
        check("stop3.count", n_stop - base_b, 1);
        check("stop3.bus_busy", 32'(a_busy), 0);
        check("stop3.bytes", n_bv - base_a, 0);
        for (int i = 0; i < 9; i++) send_bit(1'b1);
        check("idle.bytes", n_bv - base_a, 0);
        check("idle.bus_busy", 32'(a_busy), 0);

        // SCL stuck low: timeout on the 20-cycle instance only
        cyc(1'b1, 1'b1);
        i2c_start();
        base_a = n_to;
        repeat (25) cyc(1'b0, 1'b0);
        check("timeout.count", n_to - base_a, 1);
        check("timeout.bus_busy", 32'(a_busy), 0);
        check("timeout.disabled_busy", 32'(b_busy), 1);
        check("timeout.disabled_count", n_to_dis, 0);
        i2c_stop();

        // SCL pulsed high before the limit: no timeout
        i2c_start();
        base_a = n_to;
        repeat (13) cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        repeat (15) cyc(1'b0, 1'b0);
        check("no_timeout.count", n_to - base_a, 0);
        check("no_timeout.bus_busy", 32'(a_busy), 1);
        i2c_stop();

        // Reset mid-byte
        i2c_start();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        base_a = n_bv;
        reset_cycle();
        check("rst_mid.bus_busy", 32'(a_busy), 0);
        check("rst_mid.rx_byte", 32'(a_rx), 0);
        cyc(1'b1, 1'b1);
        check("rst_mid.bytes", n_bv - base_a, 0);

        // Randomized bus activity, including conditions coincident with
        // SCL edges, long SCL-low stretches and occasional reset.
        for (int op = 0; op < 500; op++) begin
            case ($urandom_range(0, 11))
                0:       i2c_start();
                1:       i2c_rstart();
                2, 3, 4, 5, 6: send_bit(1'($urandom));
                7:       i2c_stop();
                8:       repeat ($urandom_range(1, 30)) cyc(1'b0, prev_sda);
                9, 10:   repeat ($urandom_range(1, 6)) cyc(1'($urandom), 1'($urandom));
                default: if ($urandom_range(0, 4) == 0) reset_cycle();
                         else send_byte(8'($urandom), 1'($urandom));
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
